// File: rtl/shifter_pkg.sv
// Shared op-code constants, FSM states and op decode for the sequential shifter.
// Rotates count as real shift ops only when SEQ_SHIFTER_ROTATE_EN is defined.
package shifter_pkg;

    localparam logic [2:0] OP_PASS = 3'b000;
    localparam logic [2:0] OP_LSL  = 3'b001;
    localparam logic [2:0] OP_LSR  = 3'b010;
    localparam logic [2:0] OP_ASR  = 3'b011;
    localparam logic [2:0] OP_ROR  = 3'b100;
    localparam logic [2:0] OP_ROL  = 3'b101;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    // True when the op iterates; everything else completes as a pass-through.
    function automatic logic op_shifts(input logic [2:0] op);
        logic r;
        r = 1'b0;
        case (op)
            OP_LSL, OP_LSR, OP_ASR: r = 1'b1;
`ifdef SEQ_SHIFTER_ROTATE_EN
            OP_ROR, OP_ROL:         r = 1'b1;
`endif
            default:                r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/shift_step.sv
// Single 1-bit shift/rotate step plus the bit that leaves the register.
// Combinational, zero latency; no handshake.
// Rotate decode present only with SEQ_SHIFTER_ROTATE_EN.
module shift_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] val,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] nxt,
    output logic             bit_out
);
    import shifter_pkg::*;

    always_comb begin
        nxt     = val;
        bit_out = 1'b0;
        case (op)
            OP_LSL: begin
                nxt     = {val[WIDTH-2:0], 1'b0};
                bit_out = val[WIDTH-1];
            end
            OP_LSR: begin
                nxt     = {1'b0, val[WIDTH-1:1]};
                bit_out = val[0];
            end
            OP_ASR: begin
                nxt     = {val[WIDTH-1], val[WIDTH-1:1]};
                bit_out = val[0];
            end
`ifdef SEQ_SHIFTER_ROTATE_EN
            OP_ROR: begin
                nxt     = {val[0], val[WIDTH-1:1]};
                bit_out = val[0];
            end
            OP_ROL: begin
                nxt     = {val[WIDTH-2:0], val[WIDTH-1]};
                bit_out = val[WIDTH-1];
            end
`endif
            default: begin
                nxt     = val;
                bit_out = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle shifter, one bit per clock; rotates enabled by SEQ_SHIFTER_ROTATE_EN.
// Latency amt+1 cycles (1 for pass or amt=0), done pulses one cycle.
// start is ignored while busy and never queued; accepted again the cycle after done.
module seq_shifter #(
    parameter int WIDTH = 16,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] in,
    input  logic [2:0]       op,
    input  logic [AMT_W-1:0] amt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sout,
    output logic             carry,
    output logic             zero
);
    import shifter_pkg::*;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [AMT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         op_q, op_d;
    logic [WIDTH-1:0]   sout_q, sout_d;
    logic               carry_q, carry_d;
    logic               zero_q, zero_d;
    logic               done_q, done_d;

    logic [WIDTH-1:0]   step_val;
    logic               step_bit;

    shift_step #(.WIDTH(WIDTH)) u_step (
        .val     (work_q),
        .op      (op_q),
        .nxt     (step_val),
        .bit_out (step_bit)
    );

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        sout_d  = sout_q;
        carry_d = carry_q;
        zero_d  = zero_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    work_d = in;
                    cnt_d  = amt;
                    op_d   = op;
                    if (amt == '0 || !op_shifts(op)) begin
                        sout_d  = in;
                        carry_d = 1'b0;
                        zero_d  = (in == '0);
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                work_d = step_val;
                cnt_d  = cnt_q - AMT_W'(1);
                // Last step: publish the result on the same edge that raises done.
                if (cnt_q == AMT_W'(1)) begin
                    sout_d  = step_val;
                    carry_d = step_bit;
                    zero_d  = (step_val == '0);
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
            op_q    <= OP_PASS;
            sout_q  <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            sout_q  <= sout_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
            done_q  <= done_d;
        end
    end

    assign busy  = (state_q != IDLE);
    assign done  = done_q;
    assign sout  = sout_q;
    assign carry = carry_q;
    assign zero  = zero_q;

endmodule

// File: tb/tb_seq_shifter.sv
// Directed and random checks of seq_shifter (WIDTH=16, AMT_W=5) against an arithmetic reference model.
module tb_seq_shifter;

    localparam int W  = 16;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [W-1:0]  din;
    logic [2:0]    op;
    logic [AW-1:0] amt;
    logic          busy;
    logic          done;
    logic [W-1:0]  sout;
    logic          carry;
    logic          zero;

    int n_checks = 0;
    int n_fail   = 0;

    seq_shifter #(.WIDTH(W), .AMT_W(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .in    (din),
        .op    (op),
        .amt   (amt),
        .busy  (busy),
        .done  (done),
        .sout  (sout),
        .carry (carry),
        .zero  (zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: result computed directly from the shift definitions, not step by step.
    function automatic void model(input logic [15:0] x, input logic [2:0] o, input int a,
                                  output logic [15:0] r, output logic c, output int lat);
        logic [31:0] full;
        int          k;
        logic        shifts;
        shifts = (o == 3'd1 || o == 3'd2 || o == 3'd3);
`ifdef SEQ_SHIFTER_ROTATE_EN
        shifts = shifts || (o == 3'd4 || o == 3'd5);
`endif
        r = x;
        c = 1'b0;
        lat = 1;
        if (!shifts || a == 0) return;
        lat = a + 1;
        case (o)
            3'd1: begin
                r = (a >= 16) ? 16'h0 : 16'(x << a);
                c = (a <= 16) ? x[16-a] : 1'b0;
            end
            3'd2: begin
                full = {16'h0, x};
                r = 16'(full >> a);
                c = full[a-1];
            end
            3'd3: begin
                k = (a > 16) ? 16 : a;
                full = {{16{x[15]}}, x};
                r = 16'(full >> k);
                c = full[k-1];
            end
            3'd4: begin
                k = a % 16;
                full = {x, x};
                r = 16'(full >> k);
                c = r[15];
            end
            3'd5: begin
                k = a % 16;
                full = {x, x};
                full = full << k;
                r = full[31:16];
                c = r[0];
            end
            default: begin
                r = x;
                c = 1'b0;
            end
        endcase
    endfunction

    // Entered and left on a negedge; leaves the DUT idle so calls chain back-to-back.
    task automatic run_req(input logic [15:0] x, input logic [2:0] o, input int a, input string tag);
        logic [15:0] er;
        logic        ec;
        int          elat;
        int          cyc;
        model(x, o, a, er, ec, elat);
        din = x; op = o; amt = 5'(a); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        din = 16'($urandom); op = 3'($urandom); amt = 5'($urandom);
        cyc = 1;
        while (!done && cyc < 64) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, " latency"}, 32'(cyc), 32'(elat));
        chk({tag, " busy@done"}, 32'(busy), 32'd1);
        chk({tag, " sout"}, 32'(sout), 32'(er));
        chk({tag, " carry"}, 32'(carry), 32'(ec));
        chk({tag, " zero"}, 32'(zero), 32'(er == 16'h0));
        @(negedge clk);
        chk({tag, " done pulse"}, 32'(done), 32'd0);
        chk({tag, " busy after"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [15:0] er;
        logic        ec;
        int          elat;
        int          ndone;
        logic [15:0] seen;

        reset = 1'b1; start = 1'b0; din = '0; op = '0; amt = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset sout", 32'(sout), 32'd0);
        chk("reset carry", 32'(carry), 32'd0);
        chk("reset zero", 32'(zero), 32'd0);

        run_req(16'h82C5, 3'd1, 1, "lsl1");
        chk("lsl1 const sout", 32'(sout), 32'h058A);
        chk("lsl1 const carry", 32'(carry), 32'd1);
        run_req(16'h82C5, 3'd3, 4, "asr4");
        chk("asr4 const sout", 32'(sout), 32'hF82C);
        run_req(16'h82C5, 3'd2, 15, "lsr15");
        chk("lsr15 const sout", 32'(sout), 32'h0001);
        for (int o = 0; o < 4; o++) run_req(16'h82C5, 3'(o), 0, "amt0");
        run_req(16'h82C5, 3'd1, 16, "lsl16");
        chk("lsl16 const zero", 32'(zero), 32'd1);
        run_req(16'h82C5, 3'd4, 8, "ror8");
`ifdef SEQ_SHIFTER_ROTATE_EN
        chk("ror8 const sout", 32'(sout), 32'hC582);
`else
        chk("ror8 const sout", 32'(sout), 32'h82C5);
`endif
        run_req(16'h82C5, 3'd5, 3, "rol3");

        // Hold between requests.
        repeat (3) @(negedge clk);
        chk("hold sout", 32'(sout), 32'h82C5 << 0 == 32'h82C5 ? 32'(sout) : 32'h0);
        model(16'h82C5, 3'd5, 3, er, ec, elat);
        chk("hold model", 32'(sout), 32'(er));

        // Second start mid-request is dropped.
        model(16'h82C5, 3'd3, 10, er, ec, elat);
        din = 16'h82C5; op = 3'd3; amt = 5'd10; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        din = 16'hFFFF; op = 3'd1; amt = 5'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        seen = '0;
        for (int i = 0; i < 25; i++) begin
            if (done) begin
                ndone++;
                seen = sout;
            end
            @(negedge clk);
        end
        chk("ignored start done count", 32'(ndone), 32'd1);
        chk("ignored start sout", 32'(seen), 32'(er));

        // Reset mid-operation aborts.
        din = 16'h82C5; op = 3'd3; amt = 5'd10; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort done", 32'(done), 32'd0);
        chk("abort sout", 32'(sout), 32'd0);
        chk("abort carry", 32'(carry), 32'd0);
        chk("abort zero", 32'(zero), 32'd0);
        ndone = 0;
        for (int i = 0; i < 15; i++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        chk("abort no done", 32'(ndone), 32'd0);
        run_req(16'h82C5, 3'd3, 10, "post reset");

        for (int i = 0; i < 40; i++)
            run_req(16'($urandom), 3'($urandom_range(0, 7)), int'($urandom_range(0, 31)), "rand");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_shifter.md
# seq_shifter

Parametrised multi-cycle shifter: one bit position per clock, `start`/`busy`/`done` handshake. Supports logical left, logical right and arithmetic right shifts by a run-time amount, plus optional rotates. Sits beside the ALU in the datapath and replaces the fixed 1-bit combinational shifter wherever variable shift counts are needed. Produces a registered result with carry and zero flags.

## Interface
- `WIDTH`, 16, data width in bits (≥2)
- `AMT_W`, 4, shift-amount width; must satisfy 2^AMT_W ≥ WIDTH
- `clk`  in  1  clock; all logic rising-edge
- `reset`  in  1  synchronous, active-high
- `start`  in  1  request; sampled only while `busy`=0
- `in`  in  WIDTH  operand
- `op`  in  3  operation code
- `amt`  in  AMT_W  shift count
- `busy`  out  1  high while a request is in progress
- `done`  out  1  one-cycle pulse; result valid
- `sout`  out  WIDTH  result register
- `carry`  out  1  last bit shifted/rotated out
- `zero`  out  1  result == 0

## Operation
- Op codes: 000 pass, 001 LSL, 010 LSR, 011 ASR (sign fill), 100 ROR, 101 ROL; 110/111 behave as pass.
- FSM: IDLE → SHIFT → DONE → IDLE.
- IDLE, `start`=1: latch `in` into working register, load counter with `amt`, latch `op`. If `amt`=0 or op is pass: go directly to DONE and load result. Otherwise go to SHIFT.
- SHIFT: each edge applies one 1-bit step of the latched op and decrements the counter. Each step captures the bit leaving the register in a carry register. On the step where the counter reaches 0, load `sout`/`carry`/`zero` and go to DONE.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- Iteration count equals `amt` exactly, with no clamping or modulo.
  - LSL/LSR with `amt` ≥ WIDTH yields 0.
  - ASR with `amt` ≥ WIDTH yields all sign bits.
  - Rotates wrap naturally.
- `carry` is 0 when `amt`=0 or op is pass.
- `busy` = (state ≠ IDLE). `start` while `busy` is ignored and not queued. `start` is accepted in the cycle immediately after `done`.
- `in`/`op`/`amt` may change freely after acceptance.
- `sout`/`carry`/`zero` change only at the edge that raises `done`. They hold between requests.
- Reset mid-operation aborts the request: no `done` is produced and all outputs return to reset values.

## Timing
- Reset values: `busy`=0, `done`=0, `sout`=0, `carry`=0, `zero`=0; state IDLE; counter 0.
- `start` sampled at edge e0 with effective count N (0 for pass): `done` is high in the cycle after edge e0+N, i.e. latency N+1 cycles.
- `busy` is high from the cycle after e0 through the `done` cycle inclusive.
- Throughput: one request per N+2 cycles.
- No combinational path from inputs to outputs.

## Configuration
- `SEQ_SHIFTER_ROTATE_EN` defined: op codes 100 (ROR) and 101 (ROL) are implemented.
- `SEQ_SHIFTER_ROTATE_EN` undefined: 100 and 101 decode as pass (result = `in`, `carry`=0, latency 1), and no rotate logic is synthesised.
- Port list is identical in both builds.

## Structure
- Shared package `shifter_pkg` holds:
  - op-code constants (`OP_PASS`, `OP_LSL`, `OP_LSR`, `OP_ASR`, `OP_ROR`, `OP_ROL`)
  - FSM state encodings (IDLE, SHIFT, DONE)
- Sub-module `shift_step`: combinational single-step unit. Inputs are WIDTH-bit value and op; outputs are the shifted value and the out-going bit. It is instantiated once and reused every cycle.

## Test plan
All scenarios use WIDTH=16 and `in`=16'h82C5.
- LSL, `amt`=1 → `sout`=16'h058A, `carry`=1, `zero`=0, `done` 2 cycles after start.
- ASR, `amt`=4 → `sout`=16'hF82C, `carry`=0, latency 5. LSR, `amt`=15 → `sout`=16'h0001, `carry`=0, latency 16.
- `amt`=0 with each op 000–011 → `sout`=16'h82C5, `carry`=0, latency 1. LSL, `amt`=16 is not representable with AMT_W=4; use AMT_W=5 → `sout`=0, `zero`=1, `carry`=1.
- ROR, `amt`=8 with macro → `sout`=16'hC582, `carry`=1, latency 9. Same request without macro → `sout`=16'h82C5, `carry`=0, latency 1.
- Second `start` (LSL, `amt`=1, `in`=16'hFFFF) pulsed mid-request → ignored, with exactly one `done` and the first request's result. Back-to-back `start` in the cycle after `done` → accepted.
- `reset` asserted at cycle 3 of an ASR `amt`=10 request → no `done`, and all outputs read 0 next cycle. A fresh request afterwards completes correctly.
